fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences the byte-addressed, big-endian instruction memory.
- Owns the fetch PC and drives the word address to the memory; the memory read path is combinational.
- Captures each returned 32-bit word, with its PC, into a small prefetch queue.
- Hands instructions to decode over a valid/ready handshake; handles redirects (branch/jump) and halt.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be 4-byte aligned.
- QUEUE_DEPTH, 2, prefetch queue entries; power of 2, legal values 2 or 4.
- HALT_WORD, 32'hFC00_0000, instruction encoding that stops fetching.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_address  out  32  byte address to instruction memory; always 4-aligned.
- imem_instruction  in  32  word returned combinationally for imem_address.
- fetch_enable  in  1  permits fetching; low pauses fetch without losing state.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored (forced to 0).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instruction  out  32  queue head instruction.
- out_pc  out  32  PC of the queue head.
- halted  out  1  HALT_WORD has been fetched; fetch is stopped.

Behaviour:
- States:
  - IDLE: reset state.
  - FETCH: active fetching.
  - HALT: fetch stopped after HALT_WORD.
- Transitions:
  - IDLE -> FETCH on fetch_enable = 1.
  - FETCH -> HALT when the captured word equals HALT_WORD.
  - HALT -> FETCH only on redirect_valid.
  - IDLE -> FETCH also on redirect_valid.
- Reset values:
  - fetch_pc = RESET_PC; imem_address = RESET_PC.
  - Queue empty; out_valid = 0; out_instruction = 0; out_pc = 0; halted = 0; state IDLE.
- Outputs:
  - imem_address is driven directly from the fetch_pc register.
  - out_* are driven from registered queue storage, with no combinational path from imem_instruction.
- Push condition:
  - Requires state FETCH, fetch_enable = 1, no redirect_valid, and (count < QUEUE_DEPTH or a pop in the same cycle).
  - On push: enqueue {imem_instruction, fetch_pc}, then fetch_pc <= fetch_pc + 4.
- Pop condition:
  - out_valid && out_ready; head advances.
  - Simultaneous push and pop keeps count unchanged, including when the queue is full.
- Latency:
  - FETCH is entered one edge after fetch_enable is seen in IDLE.
  - The first push occurs on the next edge; out_valid rises after that edge.
  - Steady state: one instruction per cycle when out_ready is held high.
- Redirect (highest priority):
  - Flushes the queue (out_valid = 0 next cycle).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; no push and no pop are counted that cycle.
  - Clears halted; state -> FETCH.
- Halt:
  - The HALT_WORD entry is itself enqueued and delivered to decode.
  - halted = 1 from the next cycle; fetch_pc is not incremented past the halt word.
  - Queued entries continue to drain normally.
- fetch_enable low: no push, fetch_pc holds, and the queue can still drain.
- Wrap-around: fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). The memory decodes only address bits [9:0].
- Reset asserted mid-operation: all state returns immediately to reset values. Queued entries are discarded.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- When defined, adds two outputs:
  - perf_fetched (32 bits): number of pushes.
  - perf_stall (32 bits): cycles in FETCH with fetch_enable = 1 and no push because the queue is full.
- Both counters reset to 0, wrap modulo 2^32, and are unaffected by redirects.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset release, fetch_enable = 1, out_ready = 1, memory preloaded with word 32'h8020_000A at address 0 -> out_valid first rises after the 2nd edge with out_pc = 0 and out_instruction = 32'h8020_000A; out_pc then advances 4, 8, 12 on consecutive cycles.
- out_ready = 0 for 6 cycles -> exactly QUEUE_DEPTH entries captured, imem_address frozen at 4*QUEUE_DEPTH; when out_ready = 1, entries are delivered in order with no loss or duplication.
- redirect_valid with redirect_pc = 32'h0000_0107 while the queue is full -> out_valid = 0 next cycle, imem_address = 32'h0000_0104, next delivered out_pc = 32'h0000_0104.
- HALT_WORD at address 8 -> PCs 0, 4, 8 delivered, halted = 1, imem_address stays 8; a later redirect to 0 clears halted and restarts fetch.
- fetch_pc = 32'hFFFF_FFFC, one push -> imem_address = 0.
- Reset asserted mid-stream with 2 entries queued -> out_valid drops asynchronously and imem_address = RESET_PC.
- With FETCH_PERF_COUNT_EN defined, out_ready = 0 for 10 cycles at depth 2 -> perf_fetched = 2, perf_stall = 8.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, captures memory words into a
// small prefetch queue and hands them to decode. Optional counters: FETCH_PERF_COUNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] HALT_WORD   = 32'hFC00_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;

  logic [31:0] q_instr [QUEUE_DEPTH];
  logic [31:0] q_pc    [QUEUE_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic full, push, pop;

  // Redirect outranks everything: it suppresses both push and pop that cycle.
  always_comb begin
    full = (count == CW'(QUEUE_DEPTH));
    pop  = out_valid && out_ready && !redirect_valid;
    push = (state == FETCH) && fetch_enable && !redirect_valid && (!full || pop);
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      state_next    = FETCH;
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
    end else begin
      case (state)
        IDLE: if (fetch_enable) state_next = FETCH;
        FETCH: begin
          if (push) begin
            if (imem_instruction == HALT_WORD) state_next = HALT;
            else fetch_pc_next = fetch_pc + 32'd4;
          end
        end
        HALT: state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_instruction;
        q_pc[tail]    <= fetch_pc;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Outputs come only from registers; stale slots read as zero when empty.
  always_comb begin
    imem_address    = fetch_pc;
    out_valid       = (count != '0);
    out_instruction = out_valid ? q_instr[head] : 32'd0;
    out_pc          = out_valid ? q_pc[head] : 32'd0;
    halted          = (state == HALT);
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if ((state == FETCH) && fetch_enable && !redirect_valid && !push)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
